// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register with IF/ID pipeline register, speculative-branch hold register,
// and a pending-redirect buffer that keeps redirects/flushes seen while fetch is stalled.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pcsel,
  input  logic [31:0] br_target,
  input  logic [31:0] jmp_target,
  input  logic        if_id_retire,
  input  logic        stall,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pcp4,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pcp4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        hold_valid,
  output logic        recov_err
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SELW  = 2;

  localparam logic [SELW-1:0] SEL_SEQ  = 2'd0;
  localparam logic [SELW-1:0] SEL_BR   = 2'd1;
  localparam logic [SELW-1:0] SEL_JMP  = 2'd2;
  localparam logic [SELW-1:0] SEL_HOLD = 2'd3;

  typedef enum logic {
    HOLD_IDLE = 1'b0,
    HOLD_SPEC = 1'b1
  } hold_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcp4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

  typedef struct packed {
    logic            valid;
    logic [SELW-1:0] sel;
    logic [XLEN-1:0] tgt;
    logic            flush;
  } pend_t;

  logic [XLEN-1:0] pc_q,      pc_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  hold_state_t     hold_state_q, hold_state_d;
  pend_t           pend_q,    pend_d;
  if_id_t          if_id_q,   if_id_d;
  logic            recov_err_q, recov_err_d;

  logic [XLEN-1:0] live_tgt;
  logic [SELW-1:0] eff_sel;
  logic [XLEN-1:0] eff_tgt;
  logic            spec_active;

  assign spec_active = (hold_state_q == HOLD_SPEC);
  assign pcp4        = pc_q + XLEN'(4);

  // Target for the live pcsel; a recovery with no speculation falls through to pc+4.
  always_comb begin
    live_tgt = pcp4;
    case (pcsel)
      SEL_BR:   live_tgt = br_target;
      SEL_JMP:  live_tgt = jmp_target;
      SEL_HOLD: live_tgt = spec_active ? hold_pc_q : pcp4;
      default:  live_tgt = pcp4;
    endcase
  end

  // Newest redirect wins over a buffered one; otherwise sequential fetch.
  always_comb begin
    eff_sel = SEL_SEQ;
    eff_tgt = pcp4;
    if (pcsel != SEL_SEQ) begin
      eff_sel = pcsel;
      eff_tgt = live_tgt;
    end else if (pend_q.valid) begin
      eff_sel = pend_q.sel;
      eff_tgt = pend_q.tgt;
    end
  end

  // Next-state logic for PC, hold FSM, pending buffer, IF/ID and error flag.
  always_comb begin
    pc_d         = pc_q;
    hold_pc_d    = hold_pc_q;
    hold_state_d = hold_state_q;
    pend_d       = pend_q;
    if_id_d      = if_id_q;
    recov_err_d  = recov_err_q;

    if (stall) begin
      if (pcsel != SEL_SEQ) begin
        pend_d.valid = 1'b1;
        pend_d.sel   = pcsel;
        pend_d.tgt   = live_tgt;
      end
      if (pcsel == SEL_BR) begin
        hold_pc_d    = pcp4;
        hold_state_d = HOLD_SPEC;
      end
      if (if_id_retire) begin
        pend_d.flush = 1'b1;
      end
    end else begin
      pc_d          = eff_tgt;
      if_id_d.pc    = pc_q;
      if_id_d.pcp4  = pcp4;
      if_id_d.instr = imem_rdata;
      if_id_d.valid = ~(if_id_retire | pend_q.flush);
      pend_d.valid  = 1'b0;
      pend_d.flush  = 1'b0;

      case (hold_state_q)
        HOLD_IDLE: begin
          if (eff_sel == SEL_BR) begin
            hold_pc_d    = pcp4;
            hold_state_d = HOLD_SPEC;
          end
        end
        HOLD_SPEC: begin
          if (eff_sel == SEL_BR) begin
            hold_pc_d = pcp4;
          end else if (eff_sel == SEL_JMP || eff_sel == SEL_HOLD) begin
            hold_state_d = HOLD_IDLE;
          end
        end
        default: hold_state_d = HOLD_IDLE;
      endcase

      if (eff_sel == SEL_HOLD && !spec_active) begin
        recov_err_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      hold_pc_q    <= '0;
      hold_state_q <= HOLD_IDLE;
      pend_q       <= '0;
      if_id_q      <= '0;
      recov_err_q  <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      hold_pc_q    <= hold_pc_d;
      hold_state_q <= hold_state_d;
      pend_q       <= pend_d;
      if_id_q      <= if_id_d;
      recov_err_q  <= recov_err_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_pcp4  = if_id_q.pcp4;
  assign if_id_instr = if_id_q.instr;
  assign if_id_valid = if_id_q.valid;
  assign hold_valid  = spec_active;
  assign recov_err   = recov_err_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: driver predicts post-edge state from a behavioural
// model and queues it; a monitor compares DUT outputs one step after each rising edge.
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk;
  logic        rst;
  logic [1:0]  pcsel;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic        if_id_retire;
  logic        stall;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] pcp4;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pcp4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        hold_valid;
  logic        recov_err;

  fetch_pc_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .pcsel(pcsel), .br_target(br_target), .jmp_target(jmp_target),
    .if_id_retire(if_id_retire), .stall(stall), .imem_rdata(imem_rdata),
    .imem_addr(imem_addr), .pcp4(pcp4), .if_id_pc(if_id_pc), .if_id_pcp4(if_id_pcp4),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid), .hold_valid(hold_valid),
    .recov_err(recov_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ipc;
    logic [31:0] ipcp4;
    logic [31:0] instr;
    logic        ivalid;
    logic        hv;
    logic        err;
  } exp_t;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] tgt;
  } redirect_t;

  exp_t      exp_q[$];
  redirect_t pend_q[$];

  // Behavioural model state
  logic [31:0] m_pc, m_hold_pc, m_ipc, m_ipcp4, m_instr;
  logic        m_hold_v, m_flush, m_ivalid, m_err;

  int tests = 0;
  int fails = 0;
  bit done  = 1'b0;

  function automatic logic [31:0] target_of(input logic [1:0] s);
    case (s)
      2'd1:    return br_target;
      2'd2:    return jmp_target;
      2'd3:    return m_hold_v ? m_hold_pc : m_pc + 32'd4;
      default: return m_pc + 32'd4;
    endcase
  endfunction

  task automatic model_step();
    redirect_t r;
    logic [1:0]  s;
    logic [31:0] t;
    exp_t e;
    if (rst) begin
      m_pc = RESET_PC; m_hold_pc = '0; m_hold_v = 1'b0; m_flush = 1'b0;
      pend_q.delete();
      m_ipc = '0; m_ipcp4 = '0; m_instr = '0; m_ivalid = 1'b0; m_err = 1'b0;
    end else if (stall) begin
      if (pcsel != 2'd0) begin
        r.sel = pcsel; r.tgt = target_of(pcsel);
        pend_q.delete();
        pend_q.push_back(r);
      end
      if (pcsel == 2'd1) begin
        m_hold_pc = m_pc + 32'd4; m_hold_v = 1'b1;
      end
      if (if_id_retire) m_flush = 1'b1;
    end else begin
      if (pcsel != 2'd0) begin
        s = pcsel; t = target_of(pcsel);
      end else if (pend_q.size() != 0) begin
        s = pend_q[0].sel; t = pend_q[0].tgt;
      end else begin
        s = 2'd0; t = m_pc + 32'd4;
      end
      m_ipc = m_pc; m_ipcp4 = m_pc + 32'd4; m_instr = mem_word(m_pc);
      m_ivalid = !(if_id_retire || m_flush);
      m_flush = 1'b0;
      pend_q.delete();
      if (s == 2'd1) begin
        m_hold_pc = m_pc + 32'd4; m_hold_v = 1'b1;
      end else if (s != 2'd0) begin
        if (s == 2'd3 && !m_hold_v) m_err = 1'b1;
        m_hold_v = 1'b0;
      end
      m_pc = t;
    end
    e.addr = m_pc; e.ipc = m_ipc; e.ipcp4 = m_ipcp4; e.instr = m_instr;
    e.ivalid = m_ivalid; e.hv = m_hold_v; e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic st, input logic ret, input logic [1:0] s,
                     input logic [31:0] br, input logic [31:0] jmp);
    @(negedge clk);
    rst = r; stall = st; if_id_retire = ret; pcsel = s; br_target = br; jmp_target = jmp;
    model_step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: compare each queued prediction after the edge it describes.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("imem_addr",   imem_addr,   e.addr);
        chk("pcp4",        pcp4,        e.addr + 32'd4);
        chk("if_id_valid", 32'(if_id_valid), 32'(e.ivalid));
        chk("hold_valid",  32'(hold_valid),  32'(e.hv));
        chk("recov_err",   32'(recov_err),   32'(e.err));
        if (e.ivalid) begin
          chk("if_id_pc",    if_id_pc,    e.ipc);
          chk("if_id_pcp4",  if_id_pcp4,  e.ipcp4);
          chk("if_id_instr", if_id_instr, e.instr);
        end
      end
    end
  end

  // Driver: directed scenarios, then randomized traffic.
  initial begin
    logic [31:0] rb, rj;
    rst = 1'b1; stall = 1'b0; if_id_retire = 1'b0; pcsel = 2'd0;
    br_target = '0; jmp_target = '0;

    cyc(1, 0, 0, 2'd0, 0, 0);
    repeat (4) cyc(0, 0, 0, 2'd0, 0, 0);
    cyc(0, 0, 0, 2'd1, 32'h0040_0100, 0);
    cyc(0, 0, 1, 2'd3, 0, 0);
    cyc(0, 0, 1, 2'd2, 0, 32'h0040_0200);
    cyc(0, 0, 0, 2'd0, 0, 0);
    cyc(0, 1, 0, 2'd2, 0, 32'h0040_0300);
    cyc(0, 1, 1, 2'd2, 0, 32'h0040_0300);
    cyc(0, 1, 0, 2'd2, 0, 32'h0040_0300);
    cyc(0, 0, 0, 2'd0, 0, 0);
    cyc(0, 0, 0, 2'd0, 0, 0);
    cyc(0, 0, 0, 2'd2, 0, 32'h0040_0020);
    cyc(0, 0, 0, 2'd3, 0, 0);
    repeat (3) cyc(0, 0, 0, 2'd0, 0, 0);
    cyc(0, 0, 0, 2'd2, 0, 32'hFFFF_FFFC);
    repeat (2) cyc(0, 0, 0, 2'd0, 0, 0);
    cyc(0, 1, 1, 2'd2, 0, 32'h1234_5678);
    cyc(0, 1, 0, 2'd1, 32'h0000_8000, 0);
    cyc(1, 1, 0, 2'd0, 0, 0);
    repeat (3) cyc(0, 0, 0, 2'd0, 0, 0);
    cyc(0, 1, 0, 2'd1, 32'h0050_0000, 0);
    cyc(0, 1, 0, 2'd3, 0, 0);
    cyc(0, 0, 0, 2'd0, 0, 0);
    cyc(0, 0, 0, 2'd0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      rb = {$urandom, 2'b00} >> 0;
      rj = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      rb = rb & 32'hFFFF_FFFC;
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)), rb, rj);
    end

    @(negedge clk);
    rst = 1'b0; stall = 1'b1; pcsel = 2'd0; if_id_retire = 1'b0;
    repeat (2) @(negedge clk);
    done = 1'b1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d undelivered predictions expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    if (!done) begin
      fails++;
      $display("FAIL timeout: got no completion expected completion by %0t", $time);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

- Fetch-stage PC register and IF/ID pipeline register; consumes the `pcsel` / `if_id_retire` redirect interface driven by the PC control logic.
- Owns the speculative-branch fall-through hold register, applies the four PC sources, and inserts bubbles into IF/ID on retire.
- Buffers redirects and flushes that arrive while the hazard unit stalls fetch, so none are lost.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- pcsel  in  2  PC source: 0 = pc+4, 1 = br_target (speculative), 2 = jmp_target, 3 = hold register (mispredict recovery)
- br_target  in  32  branch target address
- jmp_target  in  32  jump target address
- if_id_retire  in  1  squash the instruction entering IF/ID at this posedge
- stall  in  1  freeze PC and IF/ID this cycle
- imem_rdata  in  32  instruction at imem_addr (combinational read, same cycle)
- imem_addr  out  32  current PC, equal to the pc register
- pcp4  out  32  pc + 4, combinational, modulo 2^32
- if_id_pc  out  32  PC of the IF/ID instruction
- if_id_pcp4  out  32  PC+4 of the IF/ID instruction
- if_id_instr  out  32  IF/ID instruction word
- if_id_valid  out  1  IF/ID holds a live instruction
- hold_valid  out  1  hold register holds an unresolved speculative fall-through
- recov_err  out  1  sticky flag: pcsel=3 was applied with hold_valid=0

## Operation
- Registers:
  - pc, hold_pc, hold_valid
  - pend_valid, pend_sel[1:0], pend_tgt[32], pend_flush
  - the IF/ID set: pc, pcp4, instr, valid
  - recov_err
- Reset values:
  - pc = RESET_PC
  - hold_pc = 0, hold_valid = 0
  - pend_valid = 0, pend_sel = 0, pend_tgt = 0, pend_flush = 0
  - if_id_pc = 0, if_id_pcp4 = 0, if_id_instr = 32'h0000_0000 (nop), if_id_valid = 0
  - recov_err = 0
- Target value per sel: 0 → pcp4, 1 → br_target, 2 → jmp_target, 3 → hold_pc, or pcp4 if hold_valid=0.
- Effective selection in a non-stalled cycle:
  - If pcsel≠0, the live pcsel wins (newest redirect).
  - Otherwise, if pend_valid, use pend_sel / pend_tgt.
  - Otherwise, use sel 0.
- Non-stalled cycle, at posedge:
  - pc ← effective target.
  - IF/ID ← {pc, pcp4, imem_rdata}; if_id_valid ← ~(if_id_retire | pend_flush).
  - pend_valid, pend_flush ← 0.
  - Effective sel 1: hold_pc ← pcp4 (current cycle), hold_valid ← 1.
  - Effective sel 2 or 3: hold_valid ← 0.
  - Effective sel 3 with hold_valid=0: recov_err ← 1.
  - Effective sel 0: hold_pc and hold_valid unchanged.
- Stalled cycle, at posedge:
  - pc and all IF/ID fields unchanged.
  - If pcsel≠0: pend_valid ← 1, pend_sel ← pcsel, pend_tgt ← target computed now; a later stalled redirect overwrites it (latest wins).
  - If pcsel=1: hold capture happens now, exactly as in a non-stalled cycle.
  - If if_id_retire: pend_flush ← 1. The flag is sticky until the first non-stalled cycle.
- State view (hold_valid):
  - IDLE → SPEC on sel 1.
  - SPEC → IDLE on sel 2 or 3.
  - SPEC → SPEC on a new sel 1 (re-captures hold_pc).
- Precedence: rst > stall > live redirect > pending redirect > sequential.

## Timing
- imem_addr and pcp4 change the cycle after a pc update; there is zero combinational path from pcsel to imem_addr.
- Redirect latency: pcsel sampled at edge N gives imem_addr = target from cycle N+1.
- The instruction fetched in cycle N appears on the IF/ID outputs in cycle N+1.
- Stall with a pending redirect: the redirect is applied at the first non-stalled edge, and imem_addr = pend_tgt one cycle later.
- Reset mid-stall or mid-speculation discards pending and hold state; the first fetch after rst deasserts is RESET_PC.
- pc wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.

## Test plan
- Reset then 4 free-running cycles with pcsel=0 → imem_addr 0x00400000, 0x00400004, 0x00400008, 0x0040000C; if_id_valid 0 on the first cycle, then 1.
- At pc=0x00400010, pcsel=1, br_target=0x00400100 → next imem_addr 0x00400100, hold_pc=0x00400014, hold_valid=1. Then pcsel=3, retire=1 → imem_addr 0x00400014, hold_valid=0, if_id_valid=0 for the squashed slot.
- pcsel=2, jmp_target=0x00400200, retire=1 → imem_addr 0x00400200, the bubble shows if_id_valid=0, if_id_instr irrelevant.
- stall=1 for 3 cycles with pcsel=2, jmp_target=0x00400300, retire=1 in the second stalled cycle → pc and IF/ID frozen. First unstalled cycle has pcsel=0 → pc ← 0x00400300, if_id_valid=0.
- pcsel=3 with hold_valid=0 at pc=0x00400020 → imem_addr 0x00400024, recov_err=1 and stays 1 until rst.
- pc=32'hFFFF_FFFC with pcsel=0 → next imem_addr 0x00000000. Assert rst while stalled with a pending redirect → imem_addr=RESET_PC, pend cleared.
